// File: rtl/trdb_pkg.sv
// Shared types for the trace debug branch-map stage: map capacity, FSM states
// and the packet record carried in the output slot.
package trdb_pkg;

  localparam int BRANCH_MAP_LEN = 31;
  localparam int BRANCH_CNT_W   = $clog2(BRANCH_MAP_LEN + 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } bm_state_e;

  typedef struct packed {
    logic [BRANCH_MAP_LEN-1:0] map;
    logic [BRANCH_CNT_W-1:0]   cnt;
    logic                      flush;
  } branch_map_t;

endpackage

// File: rtl/trdb_branch_map.sv
// Packs retired conditional-branch outcomes into a map (1 = not taken) and
// emits it through a one-entry slot when full or on a discontinuity.
module trdb_branch_map
  import trdb_pkg::*;
#(
  parameter int MAP_LEN = BRANCH_MAP_LEN,
  parameter int CNT_W   = $clog2(MAP_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               is_branch_i,
  input  logic               taken_i,
  input  logic               flush_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [MAP_LEN-1:0] map_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               flush_o
);

  bm_state_e    state_q, state_d;
  logic [MAP_LEN-1:0] coll_map_q, coll_map_d;
  logic [CNT_W-1:0]   coll_cnt_q, coll_cnt_d;
  logic               coll_flush_q, coll_flush_d;
  branch_map_t        slot_q, slot_d;
  logic               slot_vld_q, slot_vld_d;

  logic [MAP_LEN-1:0] add_map;
  logic [CNT_W-1:0]   add_cnt;
  logic               slot_free;
  logic               load;
  logic [MAP_LEN-1:0] load_map;
  logic [CNT_W-1:0]   load_cnt;
  logic               load_flush;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= COLLECT;
      coll_map_q   <= '0;
      coll_cnt_q   <= '0;
      coll_flush_q <= 1'b0;
      slot_q       <= '0;
      slot_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      coll_map_q   <= coll_map_d;
      coll_cnt_q   <= coll_cnt_d;
      coll_flush_q <= coll_flush_d;
      slot_q       <= slot_d;
      slot_vld_q   <= slot_vld_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    coll_map_d   = coll_map_q;
    coll_cnt_d   = coll_cnt_q;
    coll_flush_d = coll_flush_q;
    slot_d       = slot_q;
    slot_vld_d   = slot_vld_q;
    ready_o      = 1'b0;
    add_map      = coll_map_q;
    add_cnt      = coll_cnt_q;
    load         = 1'b0;
    load_map     = '0;
    load_cnt     = '0;
    load_flush   = 1'b0;
    slot_free    = !slot_vld_q || ready_i;

    case (state_q)
      COLLECT: begin
        ready_o = 1'b1;
        if (valid_i) begin
          if (is_branch_i) begin
            add_map = coll_map_q | (MAP_LEN'(!taken_i) << coll_cnt_q);
            add_cnt = coll_cnt_q + CNT_W'(1);
          end
          coll_map_d = add_map;
          coll_cnt_d = add_cnt;
          if (add_cnt == CNT_W'(MAP_LEN) || (flush_i && add_cnt != '0)) begin
            if (slot_free) begin
              load       = 1'b1;
              load_map   = add_map;
              load_cnt   = add_cnt;
              load_flush = flush_i;
              coll_map_d = '0;
              coll_cnt_d = '0;
            end else begin
              // Keep the finished map in the collector until the slot drains.
              state_d      = HOLD;
              coll_flush_d = flush_i;
            end
          end
        end
      end
      HOLD: begin
        if (slot_vld_q && ready_i) begin
          load         = 1'b1;
          load_map     = coll_map_q;
          load_cnt     = coll_cnt_q;
          load_flush   = coll_flush_q;
          coll_map_d   = '0;
          coll_cnt_d   = '0;
          coll_flush_d = 1'b0;
          state_d      = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    if (load) begin
      slot_d.map   = BRANCH_MAP_LEN'(load_map);
      slot_d.cnt   = BRANCH_CNT_W'(load_cnt);
      slot_d.flush = load_flush;
      slot_vld_d   = 1'b1;
    end else if (ready_i) begin
      slot_vld_d = 1'b0;
    end
  end

  assign valid_o = slot_vld_q;
  assign map_o   = slot_q.map[MAP_LEN-1:0];
  assign cnt_o   = slot_q.cnt[CNT_W-1:0];
  assign flush_o = slot_q.flush;

endmodule

// File: tb/tb_trdb_branch_map.sv
// Branch-map bench: fixed vector table, directed corner sequences and a random
// run, all compared against a queue-based reference model.
module tb_trdb_branch_map;
  localparam int ML = 31;
  localparam int CW = $clog2(ML + 1);

  logic          clk_i = 1'b0;
  logic          rst_i, valid_i, is_branch_i, taken_i, flush_i, ready_i;
  logic          ready_o, valid_o, flush_o;
  logic [ML-1:0] map_o;
  logic [CW-1:0] cnt_o;

  int checks = 0;
  int errors = 0;

  trdb_branch_map dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .is_branch_i(is_branch_i), .taken_i(taken_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .map_o(map_o), .cnt_o(cnt_o),
    .flush_o(flush_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: pending branch outcomes as a bit queue plus the visible packet.
  bit          m_bits[$];
  bit          m_hold;
  bit          m_hold_flush;
  bit          m_vld;
  bit [ML-1:0] m_map;
  int          m_cnt;
  bit          m_flush;

  function automatic void model_reset();
    m_bits.delete();
    m_hold = 0; m_hold_flush = 0;
    m_vld = 0; m_map = '0; m_cnt = 0; m_flush = 0;
  endfunction

  function automatic void model_emit(bit fl);
    m_map = '0;
    foreach (m_bits[i]) m_map[i] = m_bits[i];
    m_cnt = m_bits.size();
    m_flush = fl;
    m_vld = 1;
    m_bits.delete();
  endfunction

  function automatic void model_step(bit v, bit br, bit tk, bit fl, bit rdy);
    bit free = !m_vld || rdy;
    bit emitted = 0;
    if (m_hold) begin
      if (m_vld && rdy) begin
        model_emit(m_hold_flush);
        m_hold = 0;
        emitted = 1;
      end
    end else if (v) begin
      if (br) m_bits.push_back(!tk);
      if (m_bits.size() == ML || (fl && m_bits.size() > 0)) begin
        if (free) begin
          model_emit(fl);
          emitted = 1;
        end else begin
          m_hold = 1;
          m_hold_flush = fl;
        end
      end
    end
    if (!emitted && rdy) m_vld = 0;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, " valid_o"}, valid_o, m_vld);
    chk({tag, " ready_o"}, ready_o, !m_hold);
    if (m_vld) begin
      chk({tag, " map_o"}, map_o, m_map);
      chk({tag, " cnt_o"}, cnt_o, m_cnt);
      chk({tag, " flush_o"}, flush_o, m_flush);
    end
  endtask

  task automatic cyc(bit v, bit br, bit tk, bit fl, bit rdy, string tag);
    valid_i = v; is_branch_i = br; taken_i = tk; flush_i = fl; ready_i = rdy;
    @(posedge clk_i);
    model_step(v, br, tk, fl, rdy);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    valid_i = 0; is_branch_i = 0; taken_i = 0; flush_i = 0; ready_i = 1;
    @(posedge clk_i);
    model_reset();
    #1;
    rst_i = 1'b0;
  endtask

  typedef struct {
    bit v, br, tk, fl, rdy;
    bit e_vld, e_rdy;
    bit [ML-1:0] e_map;
    int e_cnt;
    bit e_flush;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1,1,0,0,1, 0,1, 31'h0, 0, 0};
    tbl[1] = '{1,1,0,0,1, 0,1, 31'h0, 0, 0};
    tbl[2] = '{1,1,0,0,1, 0,1, 31'h0, 0, 0};
    tbl[3] = '{1,0,0,1,1, 1,1, 31'h7, 3, 1};
    tbl[4] = '{1,1,1,1,1, 1,1, 31'h0, 1, 1};
    tbl[5] = '{1,0,0,1,1, 0,1, 31'h0, 0, 0};
    tbl[6] = '{0,0,0,0,1, 0,1, 31'h0, 0, 0};

    do_reset();
    chk("reset valid_o", valid_o, 0);
    chk("reset ready_o", ready_o, 1);
    chk("reset map_o", map_o, 0);
    chk("reset cnt_o", cnt_o, 0);
    chk("reset flush_o", flush_o, 0);

    // Table: three not-taken + flush, flush on taken branch at cnt 0, lone flush.
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].v, tbl[i].br, tbl[i].tk, tbl[i].fl, tbl[i].rdy, "tbl");
      chk($sformatf("tbl%0d valid_o", i), valid_o, tbl[i].e_vld);
      chk($sformatf("tbl%0d ready_o", i), ready_o, tbl[i].e_rdy);
      if (tbl[i].e_vld) begin
        chk($sformatf("tbl%0d map_o", i), map_o, tbl[i].e_map);
        chk($sformatf("tbl%0d cnt_o", i), cnt_o, tbl[i].e_cnt);
        chk($sformatf("tbl%0d flush_o", i), flush_o, tbl[i].e_flush);
      end
    end

    // 31 alternating branches, bit 0 taken.
    for (int i = 0; i < ML; i++) begin
      cyc(1, 1, (i % 2) == 0, 0, 1, "alt");
      if (i == ML - 2) chk("alt no early packet", valid_o, 0);
    end
    chk("alt valid_o", valid_o, 1);
    chk("alt map_o", map_o, 31'h2AAAAAAA);
    chk("alt cnt_o", cnt_o, 31);
    chk("alt flush_o", flush_o, 0);
    cyc(0, 0, 0, 0, 1, "alt drain");

    // Two full maps against a stalled consumer.
    for (int i = 0; i < ML; i++) cyc(1, 1, 0, 0, 0, "fill1");
    chk("hold first valid", valid_o, 1);
    chk("hold first map", map_o, 31'h7FFFFFFF);
    for (int i = 0; i < ML; i++) cyc(1, 1, 1, 0, 0, "fill2");
    chk("hold ready_o low", ready_o, 0);
    chk("hold first stable", map_o, 31'h7FFFFFFF);
    cyc(1, 1, 0, 1, 0, "hold ignored");
    chk("hold still stalled", ready_o, 0);
    cyc(0, 0, 0, 0, 1, "hold release");
    chk("release valid_o", valid_o, 1);
    chk("release map_o", map_o, 31'h0);
    chk("release cnt_o", cnt_o, 31);
    chk("release ready_o", ready_o, 1);
    cyc(0, 0, 0, 0, 0, "post release");

    // Reset while holding with a pending packet.
    for (int i = 0; i < ML; i++) cyc(1, 1, 1, 0, 0, "fill3");
    chk("pre-reset hold", ready_o, 0);
    do_reset();
    chk("mid reset valid_o", valid_o, 0);
    chk("mid reset ready_o", ready_o, 1);
    cyc(1, 0, 0, 1, 1, "lone flush");
    chk("lone flush no packet", valid_o, 0);

    // Five branches interleaved with non-branch samples, then 26 more.
    for (int i = 0; i < 10; i++) cyc(1, (i % 2) == 0, 0, 0, 1, "mix");
    chk("mix no packet", valid_o, 0);
    for (int i = 0; i < 26; i++) cyc(1, 1, 1, 0, 1, "mix fill");
    chk("mix valid_o", valid_o, 1);
    chk("mix cnt_o", cnt_o, 31);
    chk("mix map_o", map_o, 31'h1F);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1),
          $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
